// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle shared by the requesting masters and the round-robin arbiter.
interface rr_hold_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           preempt;

  // Requester side: raises requests, observes grants.
  modport master (
    output req,
    input  gnt, gnt_valid, gnt_id, preempt
  );

  // Arbiter side: samples requests, drives grants.
  modport slave (
    input  req,
    output gnt, gnt_valid, gnt_id, preempt
  );
endinterface

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter for N requesters with a per-owner hold limit.
// Priority rotates from the last owner; an owner that keeps requesting is
// rotated out after MAX_HOLD consecutive grant cycles if anyone else waits.
module rr_hold_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = 2
) (
  input logic               clk,
  input logic               rst,
  rr_hold_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t         state,     state_n;
  logic [N-1:0]   gnt_q,     gnt_n;
  logic [IDW-1:0] gnt_id_q,  gnt_id_n;
  logic           valid_q,   valid_n;
  logic           preempt_q, preempt_n;
  logic [7:0]     hold_cnt,  hold_n;
  logic [IDW-1:0] last_id,   last_n;

  logic [N-1:0]   cand;
  logic           found;
  logic [IDW-1:0] win;
  logic           owner_req;

  // Priority search: first candidate at or after last_id+1, wrapping N-1 -> 0.
  // The current owner is masked out, so in GRANT this only sees other requesters.
  always_comb begin
    cand  = bus.req & ~gnt_q;
    found = 1'b0;
    win   = '0;
    for (int o = 1; o <= N; o++) begin
      if (!found && cand[(int'(last_id) + o) % N]) begin
        found = 1'b1;
        win   = IDW'((int'(last_id) + o) % N);
      end
    end
  end

  assign owner_req = |(bus.req & gnt_q);

  // Next-state and next-output decision for the IDLE/GRANT machine.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_n   = state;
    gnt_n     = gnt_q;
    gnt_id_n  = gnt_id_q;
    valid_n   = valid_q;
    preempt_n = 1'b0;
    hold_n    = hold_cnt;
    last_n    = last_id;

    unique case (state)
      IDLE: begin
        if (found) begin
          state_n       = GRANT;
          gnt_n         = '0;
          gnt_n[win]    = 1'b1;
          gnt_id_n      = win;
          valid_n       = 1'b1;
          last_n        = win;
          hold_n        = '0;
        end
      end

      GRANT: begin
        if (!owner_req) begin
          hold_n = '0;
          if (found) begin
            // Direct handover, no idle bubble.
            gnt_n      = '0;
            gnt_n[win] = 1'b1;
            gnt_id_n   = win;
            last_n     = win;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            valid_n = 1'b0;
          end
        end else if (hold_cnt == HOLD_LAST) begin
          hold_n = '0;
          if (found) begin
            // Hold limit reached while others wait: force rotation.
            gnt_n      = '0;
            gnt_n[win] = 1'b1;
            gnt_id_n   = win;
            last_n     = win;
            preempt_n  = 1'b1;
          end
        end else begin
          hold_n = hold_cnt + 8'd1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset drops the grant immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
      hold_cnt  <= '0;
      last_id   <= IDW'(N - 1);
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state     <= state_n;
      gnt_q     <= gnt_n;
      gnt_id_q  <= gnt_id_n;
      valid_q   <= valid_n;
      preempt_q <= preempt_n;
      hold_cnt  <= hold_n;
      last_id   <= last_n;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Self-checking bench for rr_hold_arbiter (N=4, MAX_HOLD=8, IDW=2).
module tb_rr_hold_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic       pre;
  } exp_t;

  exp_t exp_q[$];

  rr_hold_arbiter_if #(.N(4), .IDW(2)) bus ();

  rr_hold_arbiter #(.N(4), .MAX_HOLD(8), .IDW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic do_reset();
    rst     = 1'b0;
    bus.req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst     = 1'b0;
    bus.req = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.gnt, bus.gnt_valid, bus.preempt, bus.gnt_id} !== 8'b0000_0_0_00) begin
      errors++;
      $display("FAIL reset_hold: got gnt=%b valid=%b preempt=%b id=%0d, required all zero",
               bus.gnt, bus.gnt_valid, bus.preempt, bus.gnt_id);
    end
    rst = 1'b1;
    exp_q.push_back('{gnt: 4'b0001, pre: 1'b0});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({bus.gnt, bus.gnt_valid, bus.preempt} !== {e.gnt, 1'b1, e.pre}) begin
      errors++;
      $display("FAIL reset_first_grant: got gnt=%b valid=%b preempt=%b, required gnt=%b valid=1 preempt=%b",
               bus.gnt, bus.gnt_valid, bus.preempt, e.gnt, e.pre);
    end
    checks++;
    if (bus.gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_first_id: got %0d, required 0", bus.gnt_id);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] rq [10] = '{4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1101,
                            4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b0000};
    logic [3:0] eg [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                            4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0000};
    exp_t e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.req = rq[i];
      exp_q.push_back('{gnt: eg[i], pre: 1'b0});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.gnt, bus.gnt_valid, bus.preempt} !== {e.gnt, |e.gnt, e.pre}) begin
        errors++;
        $display("FAIL rotation step %0d: got gnt=%b valid=%b preempt=%b, required gnt=%b valid=%b preempt=%b",
                 i, bus.gnt, bus.gnt_valid, bus.preempt, e.gnt, |e.gnt, e.pre);
      end
      if (e.gnt != 4'b0000) begin
        checks++;
        if (bus.gnt_id !== oh2idx(e.gnt)) begin
          errors++;
          $display("FAIL rotation_id step %0d: got %0d, required %0d", i, bus.gnt_id, oh2idx(e.gnt));
        end
      end
    end
  endtask

  task automatic test_hold_limit();
    exp_t e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.req = (i < 3) ? 4'b0001 : 4'b0101;
      if (i < 8)       exp_q.push_back('{gnt: 4'b0001, pre: 1'b0});
      else if (i == 8) exp_q.push_back('{gnt: 4'b0100, pre: 1'b1});
      else             exp_q.push_back('{gnt: 4'b0100, pre: 1'b0});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.gnt, bus.gnt_valid, bus.preempt} !== {e.gnt, 1'b1, e.pre}) begin
        errors++;
        $display("FAIL hold_limit step %0d: got gnt=%b valid=%b preempt=%b, required gnt=%b valid=1 preempt=%b",
                 i, bus.gnt, bus.gnt_valid, bus.preempt, e.gnt, e.pre);
      end
    end
  endtask

  task automatic test_sole_holder();
    exp_t e;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      bus.req = 4'b0010;
      exp_q.push_back('{gnt: 4'b0010, pre: 1'b0});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.gnt, bus.gnt_valid, bus.preempt, bus.gnt_id} !== {e.gnt, 1'b1, e.pre, 2'd1}) begin
        errors++;
        $display("FAIL sole_holder step %0d: got gnt=%b valid=%b preempt=%b id=%0d, required gnt=%b valid=1 preempt=%b id=1",
                 i, bus.gnt, bus.gnt_valid, bus.preempt, bus.gnt_id, e.gnt, e.pre);
      end
    end
  endtask

  task automatic test_wrap_idle();
    logic [3:0] rq [4] = '{4'b0100, 4'b1000, 4'b0000, 4'b1001};
    logic [3:0] eg [4] = '{4'b0100, 4'b1000, 4'b0000, 4'b0001};
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req = rq[i];
      exp_q.push_back('{gnt: eg[i], pre: 1'b0});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.gnt, bus.gnt_valid, bus.preempt} !== {e.gnt, |e.gnt, e.pre}) begin
        errors++;
        $display("FAIL wrap_idle step %0d: got gnt=%b valid=%b preempt=%b, required gnt=%b valid=%b preempt=%b",
                 i, bus.gnt, bus.gnt_valid, bus.preempt, e.gnt, |e.gnt, e.pre);
      end
      if (e.gnt != 4'b0000) begin
        checks++;
        if (bus.gnt_id !== oh2idx(e.gnt)) begin
          errors++;
          $display("FAIL wrap_idle_id step %0d: got %0d, required %0d", i, bus.gnt_id, oh2idx(e.gnt));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b0100;
    @(posedge clk);
    #1;
    checks++;
    if (bus.gnt !== 4'b0100) begin
      errors++;
      $display("FAIL async_reset_setup: got gnt=%b, required 0100", bus.gnt);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, bus.gnt_valid, bus.preempt} !== 6'b0000_0_0) begin
      errors++;
      $display("FAIL async_reset_drop: got gnt=%b valid=%b preempt=%b, required gnt=0000 valid=0 preempt=0",
               bus.gnt, bus.gnt_valid, bus.preempt);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bus.req = 4'b0000;
    test_reset();
    test_rotation();
    test_hold_limit();
    test_sole_holder();
    test_wrap_idle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
